// File: rtl/pwm_capture.sv
// pwm_capture: single-channel PWM decoder.
// Measures the period (rise to rise) and the high time of pwm_in in clk
// cycles and reports both with a one-cycle valid strobe. If no rising edge
// arrives within TIMEOUT cycles, the input is flagged stuck.
// Build option: define PWMCAP_SYNC_EN to condition pwm_in through a two-flop
// synchronizer (asynchronous sources). Leave it undefined for sources that
// already live in the clk domain, where a single register is used instead.
//
// Output handshake: valid is a pure strobe with no ready/back-pressure. It is
// high for exactly one cycle whenever period and duty take new values, and
// period/duty hold steady at all other times. A consumer that wants the value
// must capture it in the valid cycle.

module pwm_capture #(
    parameter int W       = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         pwm_in,
    output logic [W-1:0] period,
    output logic [W-1:0] duty,
    output logic         valid,
    output logic         stuck,
    output logic         level,
    output logic [1:0]   dbg_state
);

    localparam int              TW      = $clog2(TIMEOUT + 1);
    localparam logic [W-1:0]    CNT_MAX = '1;
    localparam logic [TW-1:0]   T_LAST  = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MEAS  = 2'd1,
        STUCK = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic          s;
    logic          s_prev;
    logic          rise;
    logic          timeout;
    logic [W-1:0]  cnt_q, cnt_d;
    logic [W-1:0]  hcnt_q, hcnt_d;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [W-1:0]  period_d;
    logic [W-1:0]  duty_d;
    logic          valid_d;
    logic          stuck_d;

`ifdef PWMCAP_SYNC_EN
    logic sync_q;

    // Two-flop synchronizer: pwm_in may change at any time relative to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            s      <= 1'b0;
        end else begin
            sync_q <= pwm_in;
            s      <= sync_q;
        end
    end
`else
    // Single sampling register: pwm_in is already synchronous to clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s <= 1'b0;
        end else begin
            s <= pwm_in;
        end
    end
`endif

    // One-cycle delayed copy of the conditioned input for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_prev <= 1'b0;
        end else begin
            s_prev <= s;
        end
    end

    assign rise      = s & ~s_prev;
    // tcnt holds the number of rise-free cycles already seen; this cycle is
    // the TIMEOUT-th one when it equals TIMEOUT-1.
    assign timeout   = (tcnt_q == T_LAST);
    assign level     = s;
    assign dbg_state = state_q;

    // State, counters and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            hcnt_q  <= '0;
            tcnt_q  <= '0;
            period  <= '0;
            duty    <= '0;
            valid   <= 1'b0;
            stuck   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hcnt_q  <= hcnt_d;
            tcnt_q  <= tcnt_d;
            period  <= period_d;
            duty    <= duty_d;
            valid   <= valid_d;
            stuck   <= stuck_d;
        end
    end

    // Next-state, counter update and report generation. A rise always takes
    // priority over a coincident timeout.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hcnt_d   = hcnt_q;
        tcnt_d   = tcnt_q;
        period_d = period;
        duty_d   = duty;
        valid_d  = 1'b0;
        stuck_d  = stuck;

        case (state_q)
            IDLE: begin
                if (rise) begin
                    // First edge only arms the measurement; nothing reported.
                    state_d = MEAS;
                    cnt_d   = W'(1);
                    hcnt_d  = W'(1);
                    tcnt_d  = '0;
                end else if (timeout) begin
                    state_d  = STUCK;
                    cnt_d    = '0;
                    hcnt_d   = '0;
                    tcnt_d   = '0;
                    period_d = '0;
                    duty_d   = '0;
                    valid_d  = 1'b1;
                    stuck_d  = 1'b1;
                end else begin
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            MEAS: begin
                if (rise) begin
                    // cnt/hcnt already include every cycle of the closing period.
                    period_d = cnt_q;
                    duty_d   = hcnt_q;
                    valid_d  = 1'b1;
                    cnt_d    = W'(1);
                    hcnt_d   = W'(1);
                    tcnt_d   = '0;
                end else if (timeout) begin
                    state_d  = STUCK;
                    cnt_d    = '0;
                    hcnt_d   = '0;
                    tcnt_d   = '0;
                    period_d = '0;
                    duty_d   = '0;
                    valid_d  = 1'b1;
                    stuck_d  = 1'b1;
                end else begin
                    // Saturate rather than wrap; hcnt <= cnt is preserved.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + W'(1);
                    end
                    if (s && (hcnt_q != CNT_MAX)) begin
                        hcnt_d = hcnt_q + W'(1);
                    end
                    tcnt_d = tcnt_q + TW'(1);
                end
            end

            STUCK: begin
                cnt_d  = '0;
                hcnt_d = '0;
                tcnt_d = '0;
                if (rise) begin
                    state_d = MEAS;
                    cnt_d   = W'(1);
                    hcnt_d  = W'(1);
                    stuck_d = 1'b0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                hcnt_d  = '0;
                tcnt_d  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture.
// Two instances share pwm_in: dut_a (TIMEOUT=50) covers normal, stuck and
// reset behaviour; dut_b (TIMEOUT=1024) covers saturation with periods longer
// than 50. Only one instance is out of reset at a time. Expected reports are
// derived from the driven waveform: every rise after the first reports the
// saturated (P, H) of the period it closes.

module tb_pwm_capture;

    localparam int W      = 8;
    localparam int TO_A   = 50;
    localparam int TO_B   = 1024;

    typedef struct {
        int p;
        int h;
        int ep;
        int ed;
        bit use_b;
    } vec_t;

    logic         clk;
    logic         rst_a_n;
    logic         rst_b_n;
    logic         pwm_in;
    logic [W-1:0] a_period, a_duty, b_period, b_duty;
    logic         a_valid, a_stuck, a_level, b_valid, b_stuck, b_level;
    logic [1:0]   a_state, b_state;

    logic [2*W-1:0] exp_q[$];
    int             n_cmp = 0;
    int             n_fail = 0;
    int             cyc = 0;
    int             last_v = -1;
    int             exp_gap = 0;
    bit             have_rise = 0;
    int             prev_ep = 0;
    int             prev_ed = 0;
    vec_t           vecs[7];

    pwm_capture #(.W(W), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst_n(rst_a_n), .pwm_in(pwm_in),
        .period(a_period), .duty(a_duty), .valid(a_valid),
        .stuck(a_stuck), .level(a_level), .dbg_state(a_state)
    );

    pwm_capture #(.W(W), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst_n(rst_b_n), .pwm_in(pwm_in),
        .period(b_period), .duty(b_duty), .valid(b_valid),
        .stuck(b_stuck), .level(b_level), .dbg_state(b_state)
    );

    // Clock and cycle counter.
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: every valid pops one expected {period, duty}.
    task automatic take(input logic [W-1:0] p, input logic [W-1:0] d);
        logic [2*W-1:0] e;
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL spare_valid: got period=%0d duty=%0d expected no report (cycle %0d)", p, d, cyc);
        end else begin
            e = exp_q.pop_front();
            check("period", int'(p), int'(e[2*W-1:W]));
            check("duty", int'(d), int'(e[W-1:0]));
            if (exp_gap != 0 && last_v >= 0) check("valid_gap", cyc - last_v, exp_gap);
        end
        last_v = cyc;
    endtask

    always @(negedge clk) begin
        if (!rst_a_n && !rst_b_n) last_v = -1;
        if (a_valid) take(a_period, a_duty);
        if (b_valid) take(b_period, b_duty);
    end

    // Driver tasks.
    task automatic tick(input logic v);
        pwm_in = v;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(input int p, input int d);
        exp_q.push_back({W'(p), W'(d)});
    endtask

    task automatic do_reset(input bit use_b, input logic line);
        pwm_in  = line;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        exp_q.delete();
        have_rise = 0;
        if (use_b) rst_b_n = 1'b1;
        else rst_a_n = 1'b1;
    endtask

    // One PWM period starting with its rising edge; the rise closes the
    // previous period, whose report is then expected.
    task automatic drive_period(input int p, input int h, input int ep, input int ed);
        if (have_rise) push_exp(prev_ep, prev_ed);
        for (int i = 0; i < p; i++) tick(i < h);
        prev_ep = ep;
        prev_ed = ed;
        have_rise = 1;
    endtask

    // A final rise to flush the last full period, then confirm all reports.
    task automatic finish_stream();
        if (have_rise) push_exp(prev_ep, prev_ed);
        tick(1'b1);
        repeat (4) tick(1'b0);
        @(negedge clk);
        #1;
        check("drained", exp_q.size(), 0);
    endtask

    // Watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: run did not finish (state a=%0d b=%0d)", a_state, b_state);
        $fatal(1);
    end

    initial begin
        int  t_hit;
        bit  found;
        int  rp, rh;

        vecs[0] = '{p: 10,  h: 3,   ep: 10,  ed: 3,   use_b: 1'b0};
        vecs[1] = '{p: 6,   h: 1,   ep: 6,   ed: 1,   use_b: 1'b0};
        vecs[2] = '{p: 6,   h: 5,   ep: 6,   ed: 5,   use_b: 1'b0};
        vecs[3] = '{p: 8,   h: 4,   ep: 8,   ed: 4,   use_b: 1'b0};
        vecs[4] = '{p: 2,   h: 1,   ep: 2,   ed: 1,   use_b: 1'b0};
        vecs[5] = '{p: 40,  h: 39,  ep: 40,  ed: 39,  use_b: 1'b0};
        vecs[6] = '{p: 300, h: 280, ep: 255, ed: 255, use_b: 1'b1};

        // Reset state.
        pwm_in  = 1'b1;
        rst_a_n = 1'b0;
        rst_b_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_period", a_period, 0);
        check("rst_duty", a_duty, 0);
        check("rst_valid", a_valid, 0);
        check("rst_stuck", a_stuck, 0);
        check("rst_level", a_level, 0);

        // Table-driven steady waveforms.
        for (int v = 0; v < 7; v++) begin
            do_reset(vecs[v].use_b, 1'b0);
            exp_gap = vecs[v].p;
            for (int k = 0; k < 3; k++) drive_period(vecs[v].p, vecs[v].h, vecs[v].ep, vecs[v].ed);
            finish_stream();
            exp_gap = 0;
        end

        // Stuck low from reset: one 0/0 report after TIMEOUT rise-free cycles.
        do_reset(1'b0, 1'b0);
        push_exp(0, 0);
        found = 0;
        t_hit = 0;
        for (int k = 1; k <= TO_A + 20; k++) begin
            tick(1'b0);
            if (a_valid) begin
                found = 1;
                t_hit = k;
                break;
            end
        end
        check("stuck_lo_found", found, 1);
        check("stuck_lo_time", t_hit, TO_A);
        repeat (3) tick(1'b0);
        check("stuck_lo_flag", a_stuck, 1);
        check("stuck_lo_level", a_level, 0);
        check("stuck_lo_period", a_period, 0);
        check("stuck_lo_duty", a_duty, 0);
        repeat (2 * TO_A) tick(1'b0);
        check("stuck_lo_hold", a_stuck, 1);
        check("stuck_lo_drained", exp_q.size(), 0);

        // Recovery from STUCK with P=8, H=4.
        tick(1'b1);
        check("recover_hold", a_stuck, 1);
        tick(1'b1);
        tick(1'b1);
        check("recover_clear", a_stuck, 0);
        tick(1'b1);
        repeat (4) tick(1'b0);
        have_rise = 1;
        prev_ep = 8;
        prev_ed = 4;
        drive_period(8, 4, 8, 4);
        drive_period(8, 4, 8, 4);
        finish_stream();
        check("recover_stuck", a_stuck, 0);

        // Stuck high: the single rise arms, then the line never rises again.
        do_reset(1'b0, 1'b1);
        push_exp(0, 0);
        found = 0;
        for (int k = 1; k <= TO_A + 20; k++) begin
            tick(1'b1);
            if (a_valid) begin
                found = 1;
                break;
            end
        end
        check("stuck_hi_found", found, 1);
        repeat (3) tick(1'b1);
        check("stuck_hi_flag", a_stuck, 1);
        check("stuck_hi_level", a_level, 1);
        check("stuck_hi_period", a_period, 0);
        check("stuck_hi_drained", exp_q.size(), 0);

        // Reset in the middle of a high phase.
        do_reset(1'b0, 1'b0);
        exp_gap = 20;
        drive_period(20, 5, 20, 5);
        drive_period(20, 5, 20, 5);
        push_exp(prev_ep, prev_ed);
        repeat (3) tick(1'b1);
        @(negedge clk);
        #1;
        rst_a_n = 1'b0;
        #1;
        check("midrst_period", a_period, 0);
        check("midrst_duty", a_duty, 0);
        check("midrst_valid", a_valid, 0);
        check("midrst_stuck", a_stuck, 0);
        check("midrst_level", a_level, 0);
        check("midrst_drained", exp_q.size(), 0);
        exp_q.delete();
        have_rise = 0;
        repeat (2) tick(1'b1);
        repeat (3) tick(1'b0);
        rst_a_n = 1'b1;
        repeat (12) tick(1'b0);
        drive_period(20, 5, 20, 5);
        drive_period(20, 5, 20, 5);
        finish_stream();
        exp_gap = 0;

        // Random periods and duties, all shorter than the timeout.
        do_reset(1'b0, 1'b0);
        for (int k = 0; k < 40; k++) begin
            rp = int'($urandom_range(2, 40));
            rh = int'($urandom_range(1, rp - 1));
            drive_period(rp, rh, rp, rh);
        end
        finish_stream();
        check("rand_no_stuck", a_stuck, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/pwm_capture.md
# pwm_capture

Single-channel PWM decoder: the receive-side counterpart of the RGB PWM generator. It samples one PWM waveform in the `clk` domain, measures the period (rising edge to rising edge) and the high time in clock cycles, and reports both with a one-cycle `valid` strobe. It also flags a stuck input, meaning no rising edge within a timeout. Instances sit on the generator outputs for loopback self-check, or on an external PWM pin.

## Interface
- `W`, 8: width of the `period` and `duty` results.
- `TIMEOUT`, 1024: cycles without a rising edge before the input is declared stuck. Legal range is 2..65535.
- `clk` input, 1: sampling clock, rising edge.
- `rst_n` input, 1: reset, asynchronous and active-low.
- `pwm_in` input, 1: PWM waveform, asynchronous to `clk`.
- `period` output, W: last measured period in cycles, saturated. Reset value 0.
- `duty` output, W: high cycles within that period, saturated. Reset value 0.
- `valid` output, 1: one-cycle pulse when `period` and `duty` update. Reset value 0.
- `stuck` output, 1: level, no rising edge within `TIMEOUT`. Reset value 0.
- `level` output, 1: the conditioned `pwm_in` (`s`). Reset value 0.

## Operation
- **Input conditioning.** `pwm_in` feeds a sampling stage that produces `s`. `s_prev` is `s` delayed by one cycle. A rising edge `rise` is `s & ~s_prev`.
- **Counters.**
  - `cnt` (W bits) counts cycles since the last rise.
  - `hcnt` (W bits) counts cycles with `s`=1 since the last rise.
  - `tcnt` (`$clog2(TIMEOUT+1)` bits) is the timeout counter.
  - `cnt` and `hcnt` saturate at 2^W−1 and never wrap.
- **States.**
  - IDLE: after reset, waiting for the first rise. On `rise`, go to MEAS with `cnt`=1, `hcnt`=1, `tcnt`=0. A partial first period is never reported.
  - MEAS: each cycle, `cnt` += 1 and `hcnt` += `s`, both saturating; `tcnt` += 1.
    - On `rise`: load `period`<=`cnt` and `duty`<=`hcnt`, pulse `valid`, then restart with `cnt`=1, `hcnt`=1, `tcnt`=0.
  - STUCK: `stuck`=1. Counters are held cleared. On `rise`, go to MEAS with `cnt`=1, `hcnt`=1, `tcnt`=0, and clear `stuck` in the same cycle.
- **Timeout.** In IDLE or MEAS, when `tcnt` reaches `TIMEOUT` without a rise, go to STUCK and set `period`=0, `duty`=0. A single `valid` pulse accompanies this update. `level` tells the consumer whether the line is stuck at 0 (0% duty) or at 1 (100% duty).
- **Invariant.** `duty` <= `period` always holds for any reported pair; saturation preserves this.
- **Simultaneous events.** If `rise` and the timeout fall in the same cycle, `rise` wins: it is a normal MEAS report or restart, with no STUCK entry.
- **Reset mid-measurement.** Asserting `rst_n` during a measurement clears all state and outputs immediately. The next report requires a full period after the first rise that follows reset.

## Timing
- `valid` is a one-cycle pulse, registered, asserted in the cycle after the clock edge at which `rise` was sampled.
- `period` and `duty` change only together with `valid` and hold otherwise.
- Input-to-`s` latency: 2 cycles with `PWMCAP_SYNC_EN`, 1 cycle without. `level` = `s`.
- For an input of period P and high time H (both < 2^W), the first report appears one full period after the first detected rise. Every subsequent period produces one report.
- Minimum measurable pulse is 1 cycle high or low. Narrower pulses may be missed.
- STUCK entry: `TIMEOUT` cycles after the last rise, or after the first IDLE cycle if no rise has occurred.

## Configuration
- Macro `PWMCAP_SYNC_EN`.
- Defined: `pwm_in` passes through a two-flop synchronizer to form `s`. Use this for external or asynchronous sources.
- Undefined: a single register forms `s`. Use this only when `pwm_in` is generated in the `clk` domain, as in loopback from the PWM core.
- The macro changes nothing else. Measured values are identical in both builds; only latency differs by one cycle.

## Test plan
- **Basic measurement.** Apply P=10, H=3, repeating. The first `valid` arrives about one period after the first rise, with `period`=10 and `duty`=3. After that, `valid` pulses exactly every 10 cycles.
- **Saturation.** With W=8, apply P=300, H=280. Every report gives `period`=255 and `duty`=255, and `duty`<=`period` holds.
- **Stuck low.** With `TIMEOUT`=50, hold the input low. After the timeout there is exactly one `valid` with `period`=0 and `duty`=0, then `stuck`=1 and `level`=0. Repeat with the input held high: same result except `level`=1.
- **Stuck recovery.** From STUCK, start P=8, H=4. `stuck` clears at the first rise. The first report is `period`=8, `duty`=4.
- **Reset mid-period.** With P=20, H=5 running, pulse `rst_n` low in the middle of a high phase. All outputs go to 0 immediately, no partial report is produced, and the next `valid` gives `period`=20, `duty`=5.
- **Boundary duty.** Apply P=6 with H=1, then with H=5. Reports are `duty`=1 and `duty`=5 respectively, with `period`=6 in both cases. No timeout occurs.
